// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU port wrapper and the memory bus
// arbiter.
//   bus_state_t   : arbiter FSM states (IDLE, BUS, RESP)
//   RW_WRITE/READ : encoding of the rw field
//   cpu_bus_req_t : one latched bus request {addr, wdata, rw}
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } bus_state_t;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rw;
   } cpu_bus_req_t;

endpackage

// File: rtl/bus_timer.sv
// bus_timer: 8-bit saturating wait counter for the arbiter watchdog.
//   clock, reset : clock and asynchronous active-low reset
//   clear        : force the count back to 0 (takes priority over enable)
//   enable       : advance the count by one (it holds at 8'hFF)
//   expired      : high while the count equals TIMEOUT-1
module bus_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] count_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= 8'd0;
      end else if (clear) begin
         count_reg <= 8'd0;
      end else if (enable && (count_reg != 8'hFF)) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory bus between port 0 (CPU) and
// port 1 (loader/DMA). Round-robin arbitration, one outstanding
// transaction, registered outputs and a wait-state watchdog.
//   clock, reset               : clock, asynchronous active-low reset
//   req/addr/wdata/rw 0 and 1  : port requests (held until ack)
//   ack0/ack1, err0/err1       : one-cycle completion, err = timed out
//   rdata                      : read data, valid in the ack cycle
//   mem_req/addr/wdata/rw      : bus request to memory
//   mem_rdata, mem_ack         : memory response
//   owner                      : port currently or last granted
module mem_bus_arbiter
   import cpu_pkg::*;
#(
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic        rw0,
   input  logic        rw1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rw,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        owner
);

   bus_state_t   state_reg, state_next;
   cpu_bus_req_t bus_reg, bus_next;
   logic         owner_reg, owner_next;
   logic         mem_req_reg, mem_req_next;
   logic [31:0]  rdata_reg, rdata_next;
   logic         ack0_reg, ack0_next, ack1_reg, ack1_next;
   logic         err0_reg, err0_next, err1_reg, err1_next;
   logic         grant;
   logic         timer_clear, timer_enable, timer_expired;

   bus_timer #(.TIMEOUT(TIMEOUT)) u_bus_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // On a tie the port that did not own the bus last time wins; a lone
   // requester always wins.
   assign grant = (req0 && req1) ? ~owner_reg : req1;

   always_comb begin
      state_next   = state_reg;
      bus_next     = bus_reg;
      owner_next   = owner_reg;
      mem_req_next = 1'b0;
      rdata_next   = rdata_reg;
      ack0_next    = 1'b0;
      ack1_next    = 1'b0;
      err0_next    = 1'b0;
      err1_next    = 1'b0;
      timer_clear  = 1'b0;
      timer_enable = 1'b0;

      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               owner_next   = grant;
               bus_next     = grant ? '{addr: addr1, wdata: wdata1, rw: rw1}
                                    : '{addr: addr0, wdata: wdata0, rw: rw0};
               timer_clear  = 1'b1;
               mem_req_next = 1'b1;
               state_next   = BUS;
            end
         end
         BUS: begin
            // A real ack in the last allowed cycle still beats the watchdog.
            if (mem_ack || timer_expired) begin
               rdata_next = mem_ack ? mem_rdata : ERR_DATA;
               ack0_next  = ~owner_reg;
               ack1_next  = owner_reg;
               err0_next  = ~owner_reg & ~mem_ack;
               err1_next  = owner_reg & ~mem_ack;
               state_next = RESP;
            end else begin
               timer_enable = 1'b1;
               mem_req_next = 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         bus_reg     <= '0;
         owner_reg   <= 1'b1;
         mem_req_reg <= 1'b0;
         rdata_reg   <= 32'd0;
         ack0_reg    <= 1'b0;
         ack1_reg    <= 1'b0;
         err0_reg    <= 1'b0;
         err1_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bus_reg     <= bus_next;
         owner_reg   <= owner_next;
         mem_req_reg <= mem_req_next;
         rdata_reg   <= rdata_next;
         ack0_reg    <= ack0_next;
         ack1_reg    <= ack1_next;
         err0_reg    <= err0_next;
         err1_reg    <= err1_next;
      end
   end

   assign mem_req   = mem_req_reg;
   assign mem_addr  = bus_reg.addr;
   assign mem_wdata = bus_reg.wdata;
   assign mem_rw    = bus_reg.rw;
   assign rdata     = rdata_reg;
   assign ack0      = ack0_reg;
   assign ack1      = ack1_reg;
   assign err0      = err0_reg;
   assign err1      = err1_reg;
   assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        rw0 = 1'b0, rw1 = 1'b0;
   logic        ack0, ack1, err0, err1, mem_req, mem_rw, owner;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int vec_cnt = 0;
   int miscompares = 0;

   mem_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR_VAL)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .rw0(rw0), .rw1(rw1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata(rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rw(mem_rw), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .owner(owner)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Advance one clock; inputs and checks land 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // {mem_req, ack0, ack1, err0, err1, owner}
   function automatic logic [5:0] ctl();
      return {mem_req, ack0, ack1, err0, err1, owner};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "bench watchdog");
   end

   initial begin
      int exp_port;

      // ---- reset then idle ----
      repeat (3) tick();
      check_val("rst_ctl", 32'(ctl()), 32'h01);
      check_val("rst_bus", mem_addr | mem_wdata | rdata | 32'(mem_rw), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val($sformatf("idle_ctl_%0d", i), 32'(ctl()), 32'h01);
      end
      check_val("idle_bus", mem_addr | mem_wdata | rdata | 32'(mem_rw), 32'd0);

      // ---- tie then alternate: expected grants 0,1,0,1 ----
      addr0 = 32'h0000_00A0; addr1 = 32'h0000_00B0;
      req0 = 1'b1; req1 = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h0000_7777;
      for (int k = 0; k < 4; k++) begin
         exp_port = k % 2;
         tick();
         check_val($sformatf("tie%0d_owner", k), 32'(owner), 32'(exp_port));
         check_val($sformatf("tie%0d_addr", k), mem_addr,
                   (exp_port == 1) ? 32'h0000_00B0 : 32'h0000_00A0);
         tick();
         check_val($sformatf("tie%0d_acks", k), {30'd0, ack1, ack0},
                   (exp_port == 1) ? 32'd2 : 32'd1);
         tick();
      end
      req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
      tick();

      // ---- single read, minimum latency ----
      addr0 = 32'h0000_0010; rw0 = 1'b0; req0 = 1'b1;
      tick();
      check_val("rd_c1_memreq", 32'(mem_req), 32'd1);
      check_val("rd_c1_addr", mem_addr, 32'h0000_0010);
      check_val("rd_c1_rw", 32'(mem_rw), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      check_val("rd_c2_ctl", 32'(ctl()), 32'b0_1_0_0_0_0);
      check_val("rd_c2_rdata", rdata, 32'hCAFE_0001);
      req0 = 1'b0; mem_ack = 1'b0;
      tick();
      check_val("rd_c3_ctl", 32'(ctl()), 32'h00);

      // ---- write with 3 wait-states, ack lands on the last allowed cycle ----
      addr1 = 32'h0000_0100; wdata1 = 32'h1234_5678; rw1 = 1'b1; req1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_val($sformatf("wr_c%0d_bus", i),
                   {mem_wdata[31:2], mem_req, mem_rw}, {30'h048D159E, 2'b11});
         check_val($sformatf("wr_c%0d_addr", i), mem_addr, 32'h0000_0100);
         check_val($sformatf("wr_c%0d_ack", i), {30'd0, ack1, ack0}, 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = 32'h0;
      tick();
      check_val("wr_c5_ctl", 32'(ctl()), 32'b0_0_1_0_0_1);
      req1 = 1'b0; mem_ack = 1'b0; rw1 = 1'b0;
      tick();

      // ---- timeout (TIMEOUT = 4) ----
      addr0 = 32'h0000_0200; req0 = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         check_val($sformatf("to_c%0d_ctl", i), 32'(ctl()), 32'b1_0_0_0_0_0);
         tick();
      end
      check_val("to_resp_ctl", 32'(ctl()), 32'b0_1_0_1_0_0);
      check_val("to_resp_rdata", rdata, ERR_VAL);
      req0 = 1'b0;
      tick();
      // next request completes normally
      addr0 = 32'h0000_0300; req0 = 1'b1;
      tick();
      check_val("post_to_memreq", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h0000_55AA;
      tick();
      check_val("post_to_ctl", 32'(ctl()), 32'b0_1_0_0_0_0);
      check_val("post_to_rdata", rdata, 32'h0000_55AA);
      req0 = 1'b0; mem_ack = 1'b0;
      tick();

      // ---- reset mid-BUS ----
      addr1 = 32'h0000_0400; req1 = 1'b1;
      tick();
      check_val("mid_bus_memreq", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_val("mid_rst_ctl", 32'(ctl()), 32'h01);
      req1 = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("after_rst_ctl_%0d", i), 32'(ctl()), 32'h01);
      end
      addr0 = 32'h0000_0500; req0 = 1'b1;
      tick();
      check_val("after_rst_addr", mem_addr, 32'h0000_0500);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      check_val("after_rst_ack", 32'(ctl()), 32'b0_1_0_0_0_0);
      check_val("after_rst_rdata", rdata, 32'h0BAD_F00D);
      req0 = 1'b0; mem_ack = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
